if_id_skid_buffer: RTL
======================

Name: if_id_skid_buffer

Overview:
IF/ID boundary buffer sitting directly downstream of the fetch stage. It captures {PC, instruction} pairs from fetch into a small circular FIFO and presents them to decode with a valid/ready handshake. Its fetch-side ready drives the program counter's ready input, so a stalled decode back-pressures PC advance. A branch-taken flush discards all buffered entries and presents a NOP bubble to decode.

Parameters:
PC_W, 64, width of the PC field
INSTR_W, 32, width of the instruction field
DEPTH, 2, number of FIFO entries; must be a power of two and >= 2
NOP_INSTR, 32'h00000013, instruction presented while dec_valid_o = 0 (addi x0,x0,0)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
reset_i  input  1  synchronous, active-low reset
fetch_valid_i  input  1  fetch presents a valid PC/instruction pair
fetch_pc_i  input  PC_W  PC of the presented instruction
fetch_instr_i  input  INSTR_W  instruction-memory output for fetch_pc_i
fetch_ready_o  output  1  buffer can accept a pair; drives the PC ready input
flush_i  input  1  branch taken; discard all entries
dec_valid_o  output  1  head entry is valid for decode
dec_pc_o  output  PC_W  PC of the head entry
dec_instr_o  output  INSTR_W  instruction of the head entry, or NOP_INSTR when invalid
dec_ready_i  input  1  decode consumes the head entry this cycle
count_o  output  $clog2(DEPTH)+1  current number of occupied entries

Behaviour:
- Reset: sampled when reset_i = 0 at a rising edge. Clears wr_ptr, rd_ptr, and count to 0. Storage contents are don't-care.
  - After reset: dec_valid_o = 0, dec_pc_o = 0, dec_instr_o = NOP_INSTR, count_o = 0.
  - fetch_ready_o is forced to 0 combinationally while reset_i = 0, so the PC holds. It is 1 on the first cycle after reset is released.
  - Reset asserted mid-operation discards all entries. Reset has priority over flush, push and pop.
- push = fetch_valid_i & fetch_ready_o & ~flush_i.
  - On push, write {fetch_pc_i, fetch_instr_i} at wr_ptr; wr_ptr advances by 1 modulo DEPTH.
- pop = dec_valid_o & dec_ready_i & ~flush_i.
  - On pop, rd_ptr advances by 1 modulo DEPTH.
- Count update:
  - count increments on push only and decrements on pop only.
  - push & pop together leaves count unchanged.
  - count never exceeds DEPTH and never goes below 0.
- fetch_ready_o = (count < DEPTH) & reset_i.
  - Depends only on registered state, with no combinational path from dec_ready_i.
  - Consequence: when full, a same-cycle pop does not admit a push. Ready rises the cycle after the pop.
- dec_valid_o = (count != 0).
  - When valid: dec_pc_o and dec_instr_o = storage[rd_ptr].
  - When invalid: dec_pc_o = 0 and dec_instr_o = NOP_INSTR.
  - Outputs come from registered state and pointers; no fetch-to-decode combinational bypass.
- Latency: a pair pushed at edge N into an empty buffer is visible on the dec_* outputs in the cycle after edge N (1 cycle).
  - Entries leave in strict push order.
- Flush: flush_i = 1 at an edge sets wr_ptr = rd_ptr = 0 and count = 0.
  - Any push or pop in that cycle is suppressed: no write, and the head is not counted as consumed.
  - The next cycle shows dec_valid_o = 0 and dec_instr_o = NOP_INSTR.
  - fetch_ready_o stays combinationally valid during flush, so the redirected PC loads. The first post-flush pair is accepted the cycle after flush deasserts.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is distinguished by count, not by pointer equality.
- Holding: while dec_valid_o = 1 and dec_ready_i = 0, dec_* outputs stay stable until popped, flushed or reset.
- fetch_* inputs are ignored when no push occurs.

Test Plan:
- Reset/idle: hold reset_i = 0 for 3 cycles with fetch_valid_i = 1 -> fetch_ready_o = 0 throughout. After release: dec_valid_o = 0, dec_instr_o = 32'h00000013, dec_pc_o = 0, count_o = 0, fetch_ready_o = 1.
- Single pass: push pc = 0x10, instr = 0x00A00093 with dec_ready_i = 1 -> the next cycle shows dec_valid_o = 1, dec_pc_o = 0x10, dec_instr_o = 0x00A00093. It is popped that cycle and count_o returns to 0.
- Back-pressure: dec_ready_i = 0 and push pc 0x0, 0x1, 0x2 on consecutive cycles -> count_o = 2 and fetch_ready_o = 0 after the 2nd push. 0x2 is not accepted. dec_pc_o holds 0x0. Raising dec_ready_i pops 0x0; fetch_ready_o = 1 the next cycle, and 0x1 then 0x2 emerge in order.
- Streaming/wrap: dec_ready_i = 1 and 10 consecutive pushes with pc 0x20..0x29 -> the same 10 pcs appear in order at 1 per cycle. count_o stays at 1 (simultaneous push/pop) and pointers wrap multiple times with no loss or duplicate.
- Flush: buffer holding 2 entries, assert flush_i for 1 cycle with fetch_valid_i = 1 and dec_ready_i = 1 -> the next cycle shows count_o = 0, dec_valid_o = 0, dec_instr_o = NOP, and no entry is consumed or written. The next push, pc = 0x80, appears 1 cycle later.
- Reset mid-operation: buffer full, then reset_i = 0 for 1 cycle together with flush_i = 1 and fetch_valid_i = 1 -> count_o = 0, dec_valid_o = 0, and fetch_ready_o = 0 during reset.

Source files
------------

// File: rtl/if_id_skid_buffer.sv
// IF/ID boundary buffer: small circular FIFO of {PC, instruction} pairs between fetch and decode.
// Fetch-side ready depends only on registered occupancy, so decode stalls back-pressure the PC.
module if_id_skid_buffer #(
   parameter int                   PC_W      = 64,
   parameter int                   INSTR_W   = 32,
   parameter int                   DEPTH     = 2,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       fetch_valid_i,
   input  logic [PC_W-1:0]            fetch_pc_i,
   input  logic [INSTR_W-1:0]         fetch_instr_i,
   output logic                       fetch_ready_o,
   input  logic                       flush_i,
   output logic                       dec_valid_o,
   output logic [PC_W-1:0]            dec_pc_o,
   output logic [INSTR_W-1:0]         dec_instr_o,
   input  logic                       dec_ready_i,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]    pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic               push_s;
   logic               pop_s;
   logic               dec_valid_s;

   assign fetch_ready_o = (count_q < CNT_W'(DEPTH)) & reset_i;
   assign dec_valid_s   = (count_q != CNT_W'(0));
   assign push_s        = fetch_valid_i & fetch_ready_o & ~flush_i;
   assign pop_s         = dec_valid_s & dec_ready_i & ~flush_i;
   assign count_o       = count_q;
   assign dec_valid_o   = dec_valid_s;

   // Pointer and occupancy next-state; flush rewinds everything and suppresses push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         count_d  = CNT_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_i;
         instr_mem_q[wr_ptr_q] <= fetch_instr_i;
      end
   end

   // Head presentation; an empty buffer shows a NOP bubble at PC 0.
   always_comb begin
      dec_pc_o    = {PC_W{1'b0}};
      dec_instr_o = NOP_INSTR;
      if (dec_valid_s) begin
         dec_pc_o    = pc_mem_q[rd_ptr_q];
         dec_instr_o = instr_mem_q[rd_ptr_q];
      end else begin
         dec_pc_o    = {PC_W{1'b0}};
         dec_instr_o = NOP_INSTR;
      end
   end

endmodule
